vce_pixel_capture: RTL and testbench

Receiving end of the HuC6260 VCE video output. Samples the 3-bit-per-channel RGB stream and active-low sync lines on each pixel strobe, recovers pixel coordinates from sync edges, crops a configured active window, and buffers pixels for a downstream framebuffer or upscaler writer over a valid/ready stream. Sits between the VCE and the HD scaler/framebuffer in the full system, in the same clock domain as the VCE.

---
 rtl/pce_capture_pkg.sv | 25 ++
 rtl/capture_fifo.sv | 54 +++++
 rtl/vce_pixel_capture.sv | 171 +++++++++++++++++
 tb/tb_vce_pixel_capture.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pce_capture_pkg.sv
// Shared types for the VCE pixel capture block.
// Holds capture FSM states, the buffered pixel record and field widths.
package pce_capture_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int RGB_W = 9;
    localparam int HC_W  = 11;
    localparam int VC_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        CAPTURE
    } cap_state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [RGB_W-1:0] rgb;
        logic             sof;
        logic             eol;
    } cap_pixel_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO for captured pixels.
// Ports: clock, reset_N (sync, active-low), push/din, pop, dout (head,
// zero when empty), full, empty.
module capture_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [29:0]
) (
    input  logic clock,
    input  logic reset_N,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T            mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    // A full FIFO still takes a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? T'(0) : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vce_pixel_capture.sv
// VCE video capture: samples RGB/sync on pixel strobes, recovers x/y from
// sync edges, crops the active window and streams pixels out via a FIFO.
// Ports: clock, reset_N, clock_en, VIDEO_R/G/B, HSYNC_n, VSYNC_n, enable,
// overflow_clr in; pix_* stream (valid/ready), overflow, frame_count out.
module vce_pixel_capture
    import pce_capture_pkg::*;
#(
    parameter int H_OFFSET   = 24,
    parameter int V_OFFSET   = 14,
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic              clock_en,
    input  logic [2:0]        VIDEO_R,
    input  logic [2:0]        VIDEO_G,
    input  logic [2:0]        VIDEO_B,
    input  logic              HSYNC_n,
    input  logic              VSYNC_n,
    input  logic              enable,
    input  logic              overflow_clr,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic [RGB_W-1:0]  pix_rgb,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              overflow,
    output logic [15:0]       frame_count
);

    cap_state_t      state;
    logic            hs_prev;
    logic            vs_prev;
    logic            hs_fall;
    logic            vs_fall;
    logic [HC_W-1:0] h_cnt;
    logic [HC_W-1:0] h_nxt;
    logic [VC_W-1:0] v_cnt;
    logic [VC_W-1:0] v_nxt;
    logic            in_win;
    logic            cap_now;
    logic            frame_any;
    cap_pixel_t      px;
    cap_pixel_t      pend;
    logic            pend_valid;
    cap_pixel_t      head;
    logic            full;
    logic            empty;
    logic            pop;
    logic            drop;

    // Counter values for the strobe being sampled now; the window test
    // and pixel coordinates use these, not the stale registered ones.
    always_comb begin
        hs_fall = hs_prev & ~HSYNC_n;
        vs_fall = vs_prev & ~VSYNC_n;
        h_nxt   = h_cnt;
        if (hs_fall) begin
            h_nxt = '0;
        end else if (h_cnt != '1) begin
            h_nxt = h_cnt + 1'b1;
        end
        v_nxt = v_cnt;
        if (vs_fall) begin
            v_nxt = '0;
        end else if (hs_fall && v_cnt != '1) begin
            v_nxt = v_cnt + 1'b1;
        end
        in_win  = int'(h_nxt) >= H_OFFSET &&
                  int'(h_nxt) <  H_OFFSET + WIDTH &&
                  int'(v_nxt) >= V_OFFSET &&
                  int'(v_nxt) <  V_OFFSET + HEIGHT;
        cap_now = clock_en && enable && state == CAPTURE && in_win;
        px.x    = X_W'(h_nxt - HC_W'(H_OFFSET));
        px.y    = Y_W'(v_nxt - VC_W'(V_OFFSET));
        px.rgb  = {VIDEO_R, VIDEO_G, VIDEO_B};
        px.sof  = (px.x == '0) && (px.y == '0);
        px.eol  = int'(px.x) == WIDTH - 1;
    end

    assign pix_valid = !empty;
    assign pop       = pix_valid && pix_ready;
    assign drop      = pend_valid && full && !pop;

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state       <= IDLE;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pend_valid  <= 1'b0;
            pend        <= '0;
            frame_any   <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (clock_en) begin
                hs_prev <= HSYNC_n;
                vs_prev <= VSYNC_n;
                h_cnt   <= h_nxt;
                v_cnt   <= v_nxt;
            end
            pend_valid <= cap_now;
            if (cap_now) begin
                pend <= px;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (clock_en && enable) begin
                        state <= SEEK;
                    end
                end
                SEEK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (clock_en && vs_fall) begin
                        state     <= CAPTURE;
                        frame_any <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (clock_en) begin
                        // Empty frames do not count as completed.
                        if (vs_fall) begin
                            if (frame_any) begin
                                frame_count <= frame_count + 1'b1;
                            end
                            frame_any <= cap_now;
                        end else if (cap_now) begin
                            frame_any <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cap_pixel_t)
    ) u_fifo (
        .clock   (clock),
        .reset_N (reset_N),
        .push    (pend_valid),
        .din     (pend),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    assign pix_x   = head.x;
    assign pix_y   = head.y;
    assign pix_rgb = head.rgb;
    assign pix_sof = head.sof;
    assign pix_eol = head.eol;

endmodule

// File: tb/tb_vce_pixel_capture.sv
// Scoreboard bench for vce_pixel_capture with a small window and FIFO.
// Stimulus drives sync-framed lines; a model queues expected pixels.
module tb_vce_pixel_capture;

    localparam int HO = 2;
    localparam int VO = 1;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FD = 4;

    logic        clock = 1'b0;
    logic        reset_N;
    logic        clock_en;
    logic [2:0]  VIDEO_R;
    logic [2:0]  VIDEO_G;
    logic [2:0]  VIDEO_B;
    logic        HSYNC_n;
    logic        VSYNC_n;
    logic        enable;
    logic        overflow_clr;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [8:0]  pix_rgb;
    logic        pix_sof;
    logic        pix_eol;
    logic        overflow;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    bit mon_on = 0;

    // reference model state
    logic [29:0] q[$];
    int          occ;
    int          mh;
    int          mv;
    bit          m_hs;
    bit          m_vs;
    int          mode;
    bit          fr_any;
    bit          pend_v;
    logic [29:0] pend_px;
    logic [15:0] exp_fc;
    bit          exp_ovf;

    vce_pixel_capture #(
        .H_OFFSET   (HO),
        .V_OFFSET   (VO),
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock        (clock),
        .reset_N      (reset_N),
        .clock_en     (clock_en),
        .VIDEO_R      (VIDEO_R),
        .VIDEO_G      (VIDEO_G),
        .VIDEO_B      (VIDEO_B),
        .HSYNC_n      (HSYNC_n),
        .VSYNC_n      (VSYNC_n),
        .enable       (enable),
        .overflow_clr (overflow_clr),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_rgb      (pix_rgb),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .overflow     (overflow),
        .frame_count  (frame_count)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: modes 0 idle, 1 waiting for a frame start, 2 capturing.
    initial forever begin
        @(posedge clock);
        if (!reset_N) begin
            q.delete();
            occ = 0; mh = 0; mv = 0; m_hs = 1; m_vs = 1;
            mode = 0; fr_any = 0; pend_v = 0;
            exp_fc = 0; exp_ovf = 0;
        end else begin
            bit pop_m, drop_m, hf, vf, push;
            pop_m  = occ > 0 && pix_ready;
            drop_m = 0;
            if (pend_v) begin
                if (occ == FD && !pop_m) begin
                    drop_m = 1;
                end else begin
                    q.push_back(pend_px);
                    occ++;
                end
            end
            if (pop_m) occ--;
            if (drop_m) exp_ovf = 1;
            else if (overflow_clr) exp_ovf = 0;
            pend_v = 0;
            if (!enable) mode = 0;
            if (clock_en) begin
                hf = m_hs && !HSYNC_n;
                vf = m_vs && !VSYNC_n;
                mh = hf ? 0 : (mh < 2047 ? mh + 1 : mh);
                if (vf) mv = 0;
                else if (hf && mv < 1023) mv = mv + 1;
                m_hs = HSYNC_n;
                m_vs = VSYNC_n;
                push = 0;
                if (mode == 0) begin
                    if (enable) mode = 1;
                end else if (mode == 1) begin
                    if (vf) begin
                        mode = 2;
                        fr_any = 0;
                    end
                end else begin
                    push = mh >= HO && mh < HO + W && mv >= VO && mv < VO + H;
                    if (push) begin
                        pend_v  = 1;
                        pend_px = {10'(mh - HO), 9'(mv - VO),
                                   VIDEO_R, VIDEO_G, VIDEO_B,
                                   1'(mh == HO && mv == VO),
                                   1'(mh == HO + W - 1)};
                    end
                    if (vf) begin
                        if (fr_any) exp_fc = exp_fc + 1'b1;
                        fr_any = push;
                    end else if (push) begin
                        fr_any = 1;
                    end
                end
            end
        end
    end

    // Monitor: compares the presented head and pops on acceptance.
    initial forever begin
        @(negedge clock);
        if (mon_on) begin
            chk("valid", 32'(pix_valid), 32'(q.size() != 0));
            if (pix_valid && q.size() != 0) begin
                chk("pixel", 32'({pix_x, pix_y, pix_rgb, pix_sof, pix_eol}),
                    32'(q[0]));
                if (pix_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rdy(int r);
        pix_ready = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
    endtask

    task automatic strobe(bit hs, bit vs, logic [8:0] rgb, int r0, int r1);
        tick();
        clock_en = 1;
        HSYNC_n  = hs;
        VSYNC_n  = vs;
        {VIDEO_R, VIDEO_G, VIDEO_B} = rgb;
        set_rdy(r0);
        repeat (3) begin
            tick();
            clock_en = 0;
            set_rdy(r1);
        end
    endtask

    // bp: 0 ready, 1 stall lines 1-2, 2 stall then release at full push,
    // 3 random ready
    task automatic do_line(int l, int rgbm, int vsp, int bp, int dis_s);
        for (int s = 0; s < 10; s++) begin
            int r0;
            int r1;
            logic [8:0] rgb;
            r0 = 1;
            r1 = 1;
            if (bp == 1 && (l == 1 || l == 2)) begin
                r0 = 0; r1 = 0;
            end else if (bp == 2) begin
                if (l == 1 || (l == 2 && s < 2)) begin
                    r0 = 0; r1 = 0;
                end else if (l == 2 && s == 2) begin
                    r0 = 0; r1 = 1;
                end
            end else if (bp == 3) begin
                r0 = 2; r1 = 2;
            end
            if (rgbm == 0) rgb = {3'(s - 2), 3'(s - 1), 3'(s)};
            else rgb = 9'($urandom);
            if (s == dis_s) enable = 0;
            strobe(s != 0, !(l == 0 && s >= vsp), rgb, r0, r1);
        end
        @(negedge clock);
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    task automatic do_frame(int rgbm, int vsp, int bp);
        for (int l = 0; l < 5; l++) do_line(l, rgbm, vsp, bp, -1);
    endtask

    initial begin
        int p0;
        reset_N = 0; enable = 0; clock_en = 0;
        HSYNC_n = 1; VSYNC_n = 1;
        VIDEO_R = 0; VIDEO_G = 0; VIDEO_B = 0;
        pix_ready = 1; overflow_clr = 0;
        repeat (3) tick();
        @(negedge clock);
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_x", 32'(pix_x), 0);
        chk("rst_y", 32'(pix_y), 0);
        chk("rst_rgb", 32'(pix_rgb), 0);
        chk("rst_sof", 32'(pix_sof), 0);
        chk("rst_eol", 32'(pix_eol), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_fc", 32'(frame_count), 0);
        mon_on = 1;
        tick();
        reset_N = 1;

        // mid-frame start: nothing until a frame start
        enable = 1;
        for (int l = 2; l < 5; l++) do_line(l, 0, 0, 0, -1);
        chk("gate_pops", 32'(pops), 0);

        // full pattern frame, then next frame start
        do_frame(0, 0, 0);
        do_line(0, 0, 0, 1, -1);
        chk("frame_pops", 32'(pops), 8);
        chk("fc_one", 32'(frame_count), 1);

        // backpressure: one stalled line fills, next line drops
        do_line(1, 0, 0, 1, -1);
        chk("bp_ovf0", 32'(overflow), 0);
        chk("bp_valid", 32'(pix_valid), 1);
        do_line(2, 0, 0, 1, -1);
        chk("bp_ovf1", 32'(overflow), 1);
        do_line(3, 0, 0, 1, -1);
        tick();
        overflow_clr = 1;
        tick();
        overflow_clr = 0;
        @(negedge clock);
        chk("ovf_clr", 32'(overflow), 0);
        do_line(4, 0, 0, 1, -1);

        // push into a full FIFO while it pops
        for (int l = 0; l < 5; l++) begin
            do_line(l, 0, 3, 2, -1);
            if (l == 2) chk("full_pushpop_ovf", 32'(overflow), 0);
        end

        // disable mid-line, re-enable mid-frame
        do_line(0, 0, 0, 0, -1);
        p0 = pops;
        do_line(1, 0, 0, 0, 4);
        chk("dis_pops", 32'(pops - p0), 2);
        chk("dis_drained", 32'(pix_valid), 0);
        do_line(2, 0, 0, 0, -1);
        enable = 1;
        do_line(3, 0, 0, 0, -1);
        do_line(4, 0, 0, 0, -1);
        chk("dis_no_push", 32'(pops - p0), 2);
        do_frame(0, 0, 0);

        // randomized frames
        for (int f = 0; f < 5; f++) begin
            do_frame(1, int'($urandom_range(0, 5)), 3);
        end

        // reset in the middle of a captured frame
        pix_ready = 1;
        do_line(0, 1, 0, 0, -1);
        do_line(1, 1, 0, 1, -1);
        tick();
        reset_N = 0;
        tick();
        reset_N = 1;
        pix_ready = 1;
        @(negedge clock);
        chk("mid_rst_valid", 32'(pix_valid), 0);
        chk("mid_rst_fc", 32'(frame_count), 0);
        enable = 1;
        for (int l = 2; l < 5; l++) do_line(l, 1, 0, 0, -1);
        do_frame(1, 0, 0);
        do_line(0, 1, 0, 0, -1);
        chk("fc_after_rst", 32'(frame_count), 1);
        repeat (10) tick();
        @(negedge clock);
        chk("drain_valid", 32'(pix_valid), 0);
        chk("drain_left", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
